// File: rtl/mpu_host_mem_responder.sv
// MPU host-memory read responder.
// Accepts a one-cycle hm_start with a 64-bit byte address, holds hm_en low
// while it fetches two 32-bit beats over a strobe/ack bus, and returns the
// assembled 64-bit word on hm_data. Aborts (range or ack timeout) return
// all-ones with hm_err set.
// Optional build macro MPU_HM_CACHE_EN adds a one-entry read cache.
module mpu_host_mem_responder #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [63:0]       hm_addr,
    input  logic              hm_start,
    output logic [63:0]       hm_data,
    output logic              hm_en,
    output logic              hm_err,
    output logic [ADDR_W-1:0] mem_adr,
    output logic              mem_stb,
    input  logic [31:0]       mem_dat_i,
    input  logic              mem_ack,
    input  logic              cache_inval
);

    localparam int CNT_W = ($clog2(TIMEOUT + 1) < 8) ? 8 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  TO_V = CNT_W'(TIMEOUT);
    localparam logic [ADDR_W-1:0] BEAT = ADDR_W'(4);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RD_LO = 2'd1;
    localparam logic [1:0] S_RD_HI = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] mem_adr_q, mem_adr_d;
    logic              mem_stb_q, mem_stb_d;
    logic [63:0]       hm_data_q, hm_data_d;
    logic              hm_en_q, hm_en_d;
    logic              hm_err_q, hm_err_d;
    logic [31:0]       lo_q, lo_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  cnt_inc;

    logic [ADDR_W-1:0] a_in;
    logic              oor;
    logic              tmo;
    logic              abort;
    logic              done;
    logic              hit;

    // Byte-offset bits are ignored; cache_inval is only consumed in the cache build.
    logic unused_ok;
    assign unused_ok = ^{hm_addr[2:0], cache_inval};

    assign a_in = {hm_addr[ADDR_W-1:3], 3'b000};

    generate
        if (ADDR_W < 64) begin : g_rng
            assign oor = |hm_addr[63:ADDR_W];
        end else begin : g_full
            assign oor = 1'b0;
        end
    endgenerate

`ifdef MPU_HM_CACHE_EN
    logic [ADDR_W-1:0] tag_q, tag_d;
    logic              cval_q, cval_d;

    // A hit needs no separate data store: every non-hit outcome either writes
    // a fresh word with valid set or clears valid, so hm_data_q is the entry.
    assign hit = cval_q && !cache_inval && (tag_q == a_in);

    // Cache tag/valid update: set on completed read, cleared on abort or inval.
    always_comb begin
        cval_d = cval_q;
        tag_d  = tag_q;
        if (done) begin
            cval_d = 1'b1;
            tag_d  = mem_adr_q - BEAT;
        end
        if (abort || cache_inval) begin
            cval_d = 1'b0;
        end
    end

    // Cache registers.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            cval_q <= 1'b0;
            tag_q  <= '0;
        end else begin
            cval_q <= cval_d;
            tag_q  <= tag_d;
        end
    end
`else
    assign hit = 1'b0;
`endif

    // Request sequencing: accept/range-check in IDLE, two bus beats, timeout abort.
    always_comb begin
        state_d   = state_q;
        mem_adr_d = mem_adr_q;
        mem_stb_d = mem_stb_q;
        hm_data_d = hm_data_q;
        hm_en_d   = hm_en_q;
        hm_err_d  = hm_err_q;
        lo_d      = lo_q;
        cnt_d     = cnt_q;
        cnt_inc   = cnt_q + 1'b1;
        tmo       = 1'b0;
        abort     = 1'b0;
        done      = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Stalls that finish without the bus last exactly one cycle.
                hm_en_d = 1'b1;
                cnt_d   = '0;
                if (hm_start) begin
                    hm_en_d = 1'b0;
                    if (oor) begin
                        hm_data_d = '1;
                        hm_err_d  = 1'b1;
                        abort     = 1'b1;
                    end else begin
                        hm_err_d = 1'b0;
                        if (!hit) begin
                            mem_adr_d = a_in;
                            mem_stb_d = 1'b1;
                            state_d   = S_RD_LO;
                        end
                    end
                end
            end
            S_RD_LO: begin
                if (mem_ack) begin
                    lo_d      = mem_dat_i;
                    mem_adr_d = mem_adr_q + BEAT;
                    cnt_d     = '0;
                    state_d   = S_RD_HI;
                end else if (cnt_inc == TO_V) begin
                    tmo = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_RD_HI: begin
                if (mem_ack) begin
                    hm_data_d = {mem_dat_i, lo_q};
                    mem_stb_d = 1'b0;
                    hm_en_d   = 1'b1;
                    state_d   = S_IDLE;
                    done      = 1'b1;
                end else if (cnt_inc == TO_V) begin
                    tmo = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d   = S_IDLE;
                mem_stb_d = 1'b0;
                hm_en_d   = 1'b1;
            end
        endcase
        if (tmo) begin
            mem_stb_d = 1'b0;
            hm_data_d = '1;
            hm_err_d  = 1'b1;
            hm_en_d   = 1'b1;
            cnt_d     = '0;
            state_d   = S_IDLE;
            abort     = 1'b1;
        end
    end

    // Responder registers; reset overrides any transfer in flight.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q   <= S_IDLE;
            mem_adr_q <= '0;
            mem_stb_q <= 1'b0;
            hm_data_q <= '0;
            hm_en_q   <= 1'b1;
            hm_err_q  <= 1'b0;
            lo_q      <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            mem_adr_q <= mem_adr_d;
            mem_stb_q <= mem_stb_d;
            hm_data_q <= hm_data_d;
            hm_en_q   <= hm_en_d;
            hm_err_q  <= hm_err_d;
            lo_q      <= lo_d;
            cnt_q     <= cnt_d;
        end
    end

    assign hm_data = hm_data_q;
    assign hm_en   = hm_en_q;
    assign hm_err  = hm_err_q;
    assign mem_adr = mem_adr_q;
    assign mem_stb = mem_stb_q;

endmodule

// File: tb/tb_mpu_host_mem_responder.sv
// Bench for mpu_host_mem_responder: transaction-level model of each request,
// a bus responder with programmable ack delay, and a per-cycle compare process.
module tb_mpu_host_mem_responder;

    localparam int TIMEOUT = 255;
`ifdef MPU_HM_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic [63:0] hm_addr = '0;
    logic        hm_start = 1'b0;
    logic [63:0] hm_data;
    logic        hm_en;
    logic        hm_err;
    logic [31:0] mem_adr;
    logic        mem_stb;
    logic [31:0] mem_dat_i = '0;
    logic        mem_ack = 1'b0;
    logic        cache_inval = 1'b0;

    mpu_host_mem_responder #(.ADDR_W(32), .TIMEOUT(TIMEOUT)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .hm_addr(hm_addr), .hm_start(hm_start),
        .hm_data(hm_data), .hm_en(hm_en), .hm_err(hm_err), .mem_adr(mem_adr),
        .mem_stb(mem_stb), .mem_dat_i(mem_dat_i), .mem_ack(mem_ack),
        .cache_inval(cache_inval)
    );

    always #5 sys_clk = ~sys_clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory contents seen by the bus responder.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h100: mem_word = 32'h1122_3344;
            32'h104: mem_word = 32'h5566_7788;
            default: mem_word = a * 32'h9E37_79B1 + 32'h0123_4567;
        endcase
    endfunction

    // Bus responder: ack after ack_dly wait cycles of each strobed beat.
    int ack_dly = 0;
    bit resp_on = 1'b1;
    initial begin
        int wcnt = 0;
        forever begin
            @(negedge sys_clk);
            if (resp_on) begin
                mem_ack = 1'b0;
                if (mem_stb) begin
                    if (wcnt >= ack_dly) begin
                        mem_ack   = 1'b1;
                        mem_dat_i = mem_word(mem_adr);
                        wcnt      = 0;
                    end else begin
                        wcnt++;
                    end
                end else begin
                    wcnt = 0;
                end
            end
        end
    end

    // Model state: result currently on the outputs, and the one pending.
    logic [63:0] cur_data = '0;
    logic        cur_err  = 1'b0;
    logic [63:0] nxt_data;
    logic        nxt_err;
    int          nxt_stall;
    bit          nxt_bus;
    logic [31:0] nxt_adrs[$];
    bit          cval = 1'b0;
    logic [31:0] ctag = '0;
    logic [63:0] cword = '0;

    task automatic model(input logic [63:0] addr, input int dly, input bit inval);
        logic [31:0] a;
        a = addr[31:0] & 32'hFFFF_FFF8;
        nxt_adrs.delete();
        if (inval) cval = 1'b0;
        if (addr[63:32] != 32'h0) begin
            nxt_data = '1; nxt_err = 1'b1; nxt_stall = 1; nxt_bus = 1'b0; cval = 1'b0;
        end else if (CACHE && cval && ctag == a) begin
            nxt_data = cword; nxt_err = 1'b0; nxt_stall = 1; nxt_bus = 1'b0;
        end else if (dly >= TIMEOUT) begin
            nxt_data = '1; nxt_err = 1'b1; nxt_stall = TIMEOUT; nxt_bus = 1'b1;
            nxt_adrs.push_back(a); cval = 1'b0;
        end else begin
            nxt_data = {mem_word(a + 32'd4), mem_word(a)};
            nxt_err = 1'b0; nxt_stall = 2 * (dly + 1); nxt_bus = 1'b1;
            nxt_adrs.push_back(a); nxt_adrs.push_back(a + 32'd4);
            cval = 1'b1; ctag = a; cword = nxt_data;
        end
    endtask

    // Per-cycle compare against the model.
    bit          chk_on = 1'b0;
    int          stall = 0;
    int          last_stall = 0;
    int          done_cnt = 0;
    bit          prev_stb = 1'b0;
    logic [31:0] prev_adr = '0;
    logic [31:0] adr_log[$];
    initial begin
        forever begin
            @(negedge sys_clk);
            if (chk_on && !sys_rst) begin
                if (mem_stb && (!prev_stb || mem_adr != prev_adr)) adr_log.push_back(mem_adr);
                prev_stb = mem_stb;
                prev_adr = mem_adr;
                if (!hm_en) begin
                    stall++;
                    if (!nxt_bus) chk("stb_without_bus", {63'd0, mem_stb}, 64'd0);
                end else begin
                    chk("stb_when_idle", {63'd0, mem_stb}, 64'd0);
                    if (stall != 0) begin
                        chk("stall_len", 64'(stall), 64'(nxt_stall));
                        chk("result_data", hm_data, nxt_data);
                        chk("result_err", {63'd0, hm_err}, {63'd0, nxt_err});
                        chk("adr_count", 64'(adr_log.size()), 64'(nxt_adrs.size()));
                        foreach (nxt_adrs[i])
                            if (i < adr_log.size()) chk("adr_seq", {32'd0, adr_log[i]}, {32'd0, nxt_adrs[i]});
                        adr_log.delete();
                        cur_data   = nxt_data;
                        cur_err    = nxt_err;
                        last_stall = stall;
                        stall      = 0;
                        done_cnt++;
                    end else begin
                        chk("hold_data", hm_data, cur_data);
                        chk("hold_err", {63'd0, hm_err}, {63'd0, cur_err});
                    end
                end
            end
        end
    end

    task automatic issue(input logic [63:0] addr, input int dly, input bit inval);
        int c0;
        @(posedge sys_clk); #1;
        model(addr, dly, inval);
        ack_dly     = dly;
        hm_addr     = addr;
        hm_start    = 1'b1;
        cache_inval = inval;
        c0          = done_cnt;
        @(posedge sys_clk); #1;
        hm_start    = 1'b0;
        cache_inval = 1'b0;
        for (int k = 0; k < 1000 && done_cnt == c0; k++) @(negedge sys_clk);
        chk("completion_seen", 64'(done_cnt), 64'(c0 + 1));
    endtask

    task automatic pulse_inval();
        @(posedge sys_clk); #1;
        cache_inval = 1'b1;
        cval = 1'b0;
        @(posedge sys_clk); #1;
        cache_inval = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge sys_clk);
        #1 sys_rst = 1'b0;
        @(negedge sys_clk);
        chk("rst_hm_en",   {63'd0, hm_en},   64'd1);
        chk("rst_hm_data", hm_data,          64'd0);
        chk("rst_hm_err",  {63'd0, hm_err},  64'd0);
        chk("rst_mem_stb", {63'd0, mem_stb}, 64'd0);
        chk("rst_mem_adr", {32'd0, mem_adr}, 64'd0);
        chk_on = 1'b1;

        // Basic read, immediate ack.
        issue(64'h100, 0, 1'b0);
        chk("lit_data_100",  hm_data, 64'h5566_7788_1122_3344);
        chk("lit_stall_100", 64'(last_stall), 64'd2);

        // Unaligned address, 3-cycle ack delay per beat.
        pulse_inval();
        issue(64'h107, 3, 1'b0);
        chk("lit_data_107",  hm_data, 64'h5566_7788_1122_3344);
        chk("lit_stall_107", 64'(last_stall), 64'd8);

        // Out of range, then a valid start clears the error.
        issue(64'h1_0000_0000, 0, 1'b0);
        chk("lit_oor_data",  hm_data, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("lit_oor_err",   {63'd0, hm_err}, 64'd1);
        chk("lit_oor_stall", 64'(last_stall), 64'd1);
        issue(64'h208, 1, 1'b0);
        chk("lit_err_clear", {63'd0, hm_err}, 64'd0);

        // Ack never arrives: timeout abort.
        issue(64'h300, 100000, 1'b0);
        chk("lit_tmo_stall", 64'(last_stall), 64'd255);
        chk("lit_tmo_err",   {63'd0, hm_err}, 64'd1);

        // Further patterns including the top of the address space.
        issue(64'h400, 2, 1'b0);
        issue(64'hFFFF_FFFF, 0, 1'b0);

        // Cache behaviour (plain bus reads when compiled out).
        issue(64'h200, 0, 1'b0);
        issue(64'h200, 0, 1'b0);
        pulse_inval();
        issue(64'h200, 1, 1'b0);
        issue(64'h200, 0, 1'b1);
        issue(64'h204, 0, 1'b0);

        // Reset during RD_HI followed by a stale ack.
        chk_on = 1'b0;
        @(posedge sys_clk); #1;
        ack_dly  = 3;
        hm_addr  = 64'h500;
        hm_start = 1'b1;
        @(posedge sys_clk); #1;
        hm_start = 1'b0;
        for (int k = 0; k < 50 && mem_adr != 32'h504; k++) @(negedge sys_clk);
        chk("reached_rd_hi", {32'd0, mem_adr}, 64'h504);
        @(posedge sys_clk); #1;
        sys_rst = 1'b1;
        resp_on = 1'b0;
        mem_ack = 1'b0;
        @(posedge sys_clk); #1;
        sys_rst   = 1'b0;
        mem_ack   = 1'b1;
        mem_dat_i = 32'hDEAD_BEEF;
        @(posedge sys_clk); #1;
        mem_ack = 1'b0;
        @(negedge sys_clk);
        chk("rstmid_hm_en",   {63'd0, hm_en},   64'd1);
        chk("rstmid_hm_data", hm_data,          64'd0);
        chk("rstmid_mem_stb", {63'd0, mem_stb}, 64'd0);
        chk("rstmid_hm_err",  {63'd0, hm_err},  64'd0);
        cur_data = '0;
        cur_err  = 1'b0;
        cval     = 1'b0;
        prev_stb = 1'b0;
        stall    = 0;
        adr_log.delete();
        resp_on  = 1'b1;
        chk_on   = 1'b1;

        // Recovery after reset.
        issue(64'h100, 0, 1'b0);
        chk("lit_data_after_rst", hm_data, 64'h5566_7788_1122_3344);

        repeat (3) @(negedge sys_clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mpu_host_mem_responder.md
Name: mpu_host_mem_responder

Overview:
- Responder side of the MPU host-memory read interface.
- Accepts a single-cycle `hm_start` with a 64-bit byte address from `mpu_top`.
- Stalls the MPU via `hm_en` while it performs two 32-bit reads on a simple strobe/ack memory bus, then returns the assembled 64-bit word on `hm_data`.
- Replaces the behavioural host-memory model and sits between `mpu_top` and the system memory bus.

Parameters:
- ADDR_W, 32, bus address width; `hm_addr` bits above ADDR_W-1 must be zero.
- TIMEOUT, 255, maximum cycles waited for `mem_ack` per beat before abort (8-bit counter minimum; width = clog2(TIMEOUT+1)).

Ports:
- sys_clk  in  1  system clock, all logic on rising edge
- sys_rst  in  1  synchronous reset, active-high
- hm_addr  in  64  byte address of 64-bit word; bits [2:0] ignored (treated as 0)
- hm_start  in  1  single-cycle read request, sampled only in IDLE
- hm_data  out  64  read result, valid whenever hm_en=1 after a completed request
- hm_en  out  1  1 = responder idle and MPU may advance; 0 = read in progress
- hm_err  out  1  1 = last request aborted (range or timeout); cleared on next accepted start
- mem_adr  out  ADDR_W  bus byte address
- mem_stb  out  1  bus request strobe
- mem_dat_i  in  32  bus read data, valid with mem_ack
- mem_ack  in  1  bus beat acknowledge
- cache_inval  in  1  invalidates optional cache; ignored when feature compiled out

Behaviour:
- Reset values: hm_data=0, hm_en=1, hm_err=0, mem_stb=0, mem_adr=0, state IDLE, timeout counter 0. Reset wins over all other events, including mid-transfer; a late mem_ack arriving in IDLE is ignored.
- States: IDLE, RD_LO, RD_HI.
- IDLE, hm_start=1, hm_addr[63:ADDR_W]==0:
  - Latch A={hm_addr[ADDR_W-1:3],3'b000}; hm_err<=0; hm_en<=0.
  - mem_adr<=A; mem_stb<=1; go RD_LO.
- IDLE, hm_start=1, out-of-range upper bits:
  - No bus access; hm_en<=0 for exactly one cycle.
  - hm_data<=64'hFFFF_FFFF_FFFF_FFFF; hm_err<=1; hm_en returns to 1 on the following edge.
- RD_LO, mem_ack=1:
  - lo<=mem_dat_i; mem_adr<=A+4 (mod 2^ADDR_W); mem_stb stays 1; counter cleared; go RD_HI.
- RD_HI, mem_ack=1:
  - hm_data<={mem_dat_i,lo} (upper word from A+4); mem_stb<=0; hm_en<=1; go IDLE.
  - hm_data and hm_en change on the same edge.
- RD_LO/RD_HI, mem_ack=0:
  - Counter increments.
  - When counter reaches TIMEOUT: mem_stb<=0; hm_data<=all-ones; hm_err<=1; hm_en<=1; go IDLE.
- Minimum latency (ack on first strobe cycle of each beat): hm_en low for exactly 2 cycles.
- hm_start outside IDLE is ignored. A start on the same edge that completes a read is ignored, since state is not yet IDLE.
- hm_data holds its value between requests; hm_err is sticky until the next accepted start.
- Address wrap: A+4 wraps at 2^ADDR_W with no error.

Optional Feature:
- Macro: MPU_HM_CACHE_EN.
- Compiled in:
  - One-entry cache: tag = last successfully read A, plus a valid bit.
  - Accepted start whose A equals the tag with valid=1 → no bus access; hm_en low one cycle; hm_data<=cached word.
  - Valid cleared by reset, by cache_inval (any state), and by any aborted request.
  - Valid set on each successful RD_HI completion.
  - cache_inval in the same cycle as a hit-start forces a miss (bus read).
- Compiled out: every in-range request uses the bus; cache_inval has no effect.

Test Plan:
- After reset, hm_start with hm_addr=0x100, memory 0x100=0x11223344, 0x104=0x55667788, ack immediate → hm_en low 2 cycles, hm_data=0x5566778811223344, hm_err=0, mem_adr sequence 0x100, 0x104.
- hm_addr=0x107, ack delayed 3 cycles per beat → reads at 0x100/0x104, hm_en low 8 cycles, correct data.
- hm_addr=0x1_0000_0000 (ADDR_W=32) → mem_stb never asserts, hm_en low 1 cycle, hm_data=all-ones, hm_err=1; next valid start clears hm_err.
- mem_ack held 0, TIMEOUT=255 → abort after 255 wait cycles in RD_LO, mem_stb drops, hm_data=all-ones, hm_err=1.
- sys_rst pulsed while in RD_HI, stale ack the cycle after → hm_en=1, hm_data=0, mem_stb=0, no data update.
- MPU_HM_CACHE_EN: two consecutive reads of 0x200 → second has no mem_stb, 1-cycle stall, same data; after cache_inval pulse, third read uses the bus.
